load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Load-side counterpart of the store formatting path.
- Accepts one load request from the execute stage and issues a word-aligned read to data memory.
- Waits for the read data, then extracts the addressed byte, halfword or word and sign- or zero-extends it to 32 bits.
- Returns the result to writeback with a single-cycle valid pulse; misaligned accesses, illegal widths and memory timeouts return an error instead.

Parameters:
- TIMEOUT, 255: WAIT-state cycle limit before an error response is returned; 0 disables the timeout.
- ADDR_W, 32: byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load request from execute.
- req_ready  output  1  unit is idle and can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_funct3  input  3  load width and signedness: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_req  output  1  read request to data memory.
- mem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00}).
- mem_gnt  input  1  memory accepted mem_req this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read word.
- rd_valid  output  1  one-cycle result strobe.
- rd_data  output  32  extended load result.
- rd_err  output  1  qualifies rd_valid; 1 = misaligned, illegal funct3 or timeout.

Behaviour:
- Reset: clk with asynchronous active-low rst_n; asserting rst_n=0 forces state IDLE immediately.
  - Reset values: req_ready=1, mem_req=0, mem_addr=0, rd_valid=0, rd_data=0, rd_err=0, timeout counter=0.
  - Reset during REQ or WAIT abandons the load. Any mem_rvalid arriving after reset release while in IDLE is ignored.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches addr and funct3.
    - Request checks: funct3 is illegal if it is 011, 110 or 111. Alignment violations are LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
    - Illegal or misaligned request: go to RESP with rd_err=1 and rd_data=0. No memory access is issued.
    - Legal request: go to REQ.
  - REQ: mem_req=1 and mem_addr held stable until mem_gnt.
    - mem_gnt=1: go to WAIT and clear the counter.
    - mem_rvalid is ignored in REQ; the memory guarantees rvalid no earlier than the cycle after gnt.
  - WAIT: the counter increments each cycle.
    - mem_rvalid=1: register the extracted data and go to RESP with rd_err=0.
    - Timeout (TIMEOUT!=0 and counter==TIMEOUT-1 without rvalid): go to RESP with rd_err=1 and rd_data=0.
    - rvalid in the same cycle as the timeout: the data wins.
  - RESP: rd_valid=1 for exactly one cycle, rd_data and rd_err valid, then return to IDLE.
    - rd_data and rd_err hold their value until the next RESP.
- Extraction and extension (byte lane chosen by addr[1:0]; little-endian):
  - LB: lane byte addr[1:0], bit 7 replicated to 31:8.
  - LBU: the same byte, zero-filled.
  - LH: halfword at addr[1]*16, bit 15 replicated.
  - LHU: the same halfword, zero-filled.
  - LW: the whole word.
- Latency, legal load with gnt in the REQ cycle and rvalid one cycle later:
  - accept at T0, REQ at T1, WAIT at T2 (rvalid), rd_valid at T3. This is the minimum of 3 cycles from handshake to result.
- Error latency: an illegal or misaligned request gives rd_valid on T1.
- Back-to-back: req_ready is 0 from T1 through RESP and returns to 1 in the IDLE cycle after RESP. A new request is never accepted in the same cycle as rd_valid.
- Exactly one outstanding memory access at a time; no pipelining.

Decomposition:
- Shared package contents:
  - funct3 load encodings (LB, LH, LW, LBU, LHU).
  - State enum (IDLE, REQ, WAIT, RESP).
  - Error cause constants, for optional debug export.
- One sub-module, load_extend: purely combinational. Inputs are word, addr[1:0] and funct3; outputs are the extended data and an align_ok flag. The alignment logic is shared with a future store-side check.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF1234, gnt in REQ, rvalid next cycle -> mem_addr=0x100; rd_data=0xFFFFFF80, rd_err=0, rd_valid 3 cycles after the handshake.
- LBU/LHU/LH at addr 0x102, mem_rdata=0x8001ABCD -> LBU=0x00000001; LHU=0x00008001; LH=0xFFFF8001.
- LW at 0x206 -> no mem_req; next cycle rd_valid=1, rd_err=1, rd_data=0. Repeat with funct3=011 and the same result.
- LW at 0x300, mem_gnt held low for 5 cycles then high, rvalid 2 cycles later with 0xDEADBEEF -> mem_req and mem_addr stable for all 6 REQ cycles; rd_data=0xDEADBEEF; req_ready=0 throughout.
- TIMEOUT=4, gnt given, rvalid never asserted -> rd_valid with rd_err=1 exactly 4 WAIT cycles after the gnt; a late rvalid is ignored and the unit returns to IDLE.
- Drive rst_n=0 asynchronously mid-WAIT, then release and pulse a stray rvalid -> all outputs are at reset values immediately; no rd_valid is produced; req_ready=1.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment path: funct3 encodings, FSM states,
// error causes and the funct3 legality check.
package load_align_unit_pkg;

   localparam logic [2:0] Funct3Lb  = 3'b000;
   localparam logic [2:0] Funct3Lh  = 3'b001;
   localparam logic [2:0] Funct3Lw  = 3'b010;
   localparam logic [2:0] Funct3Lbu = 3'b100;
   localparam logic [2:0] Funct3Lhu = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StResp
   } state_e;

   // Error causes, available for debug export.
   localparam logic [1:0] ErrNone     = 2'd0;
   localparam logic [1:0] ErrMisalign = 2'd1;
   localparam logic [1:0] ErrFunct3   = 2'd2;
   localparam logic [1:0] ErrTimeout  = 2'd3;

   function automatic logic funct3_legal(input logic [2:0] f3);
      return (f3 == Funct3Lb) || (f3 == Funct3Lh) || (f3 == Funct3Lw) ||
             (f3 == Funct3Lbu) || (f3 == Funct3Lhu);
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a little-endian load word,
// plus the natural-alignment check for the access width.
module load_extend
   import load_align_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o,
   output logic        align_ok_o
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      lane_byte = word_i[{offset_i, 3'b000} +: 8];
      lane_half = offset_i[1] ? word_i[31:16] : word_i[15:0];

      data_o     = 32'h0;
      align_ok_o = 1'b1;
      case (funct3_i)
         Funct3Lb:  data_o = {{24{lane_byte[7]}}, lane_byte};
         Funct3Lbu: data_o = {24'h0, lane_byte};
         Funct3Lh: begin
            data_o     = {{16{lane_half[15]}}, lane_half};
            align_ok_o = ~offset_i[0];
         end
         Funct3Lhu: begin
            data_o     = {16'h0, lane_half};
            align_ok_o = ~offset_i[0];
         end
         Funct3Lw: begin
            data_o     = word_i;
            align_ok_o = (offset_i == 2'b00);
         end
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: issues a word-aligned read, extracts and extends
// the addressed lane, and returns it (or an error) with a one-cycle strobe.
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              rd_valid,
   output logic [31:0]       rd_data,
   output logic              rd_err
);

   state_e            state_q, state_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;

   logic [1:0]  ext_off;
   logic [2:0]  ext_f3;
   logic [31:0] ext_data;
   logic        ext_align_ok;

   // In IDLE the extender checks the incoming request; afterwards it formats the latched one.
   assign ext_off = (state_q == StIdle) ? req_addr[1:0] : addr_lo_q;
   assign ext_f3  = (state_q == StIdle) ? req_funct3 : funct3_q;

   load_extend u_load_extend (
      .word_i     (mem_rdata),
      .offset_i   (ext_off),
      .funct3_i   (ext_f3),
      .data_o     (ext_data),
      .align_ok_o (ext_align_ok)
   );

   always_comb begin
      state_d    = state_q;
      addr_lo_d  = addr_lo_q;
      funct3_d   = funct3_q;
      mem_addr_d = mem_addr_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_lo_d = req_addr[1:0];
               funct3_d  = req_funct3;
               if (!funct3_legal(req_funct3) || !ext_align_ok) begin
                  rd_data_d = 32'h0;
                  rd_err_d  = 1'b1;
                  state_d   = StResp;
               end else begin
                  mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  state_d    = StReq;
               end
            end
         end
         StReq: begin
            if (mem_gnt) begin
               cnt_d   = 32'h0;
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 32'd1;
            // Data arriving on the timeout cycle still wins.
            if (mem_rvalid) begin
               rd_data_d = ext_data;
               rd_err_d  = 1'b0;
               state_d   = StResp;
            end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
               rd_data_d = 32'h0;
               rd_err_d  = 1'b1;
               state_d   = StResp;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_lo_q  <= 2'b00;
         funct3_q   <= 3'b000;
         mem_addr_q <= '0;
         cnt_q      <= 32'h0;
         rd_data_q  <= 32'h0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_lo_q  <= addr_lo_d;
         funct3_q   <= funct3_d;
         mem_addr_q <= mem_addr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign req_ready = (state_q == StIdle);
   assign mem_req   = (state_q == StReq);
   assign mem_addr  = mem_addr_q;
   assign rd_valid  = (state_q == StResp);
   assign rd_data   = rd_data_q;
   assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: stimulus pushes expected responses into a
// queue, and a negedge monitor pops and compares on every rd_valid strobe.
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [32:0] exp_q[$];

   load_align_unit #(
      .TIMEOUT (4),
      .ADDR_W  (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: every result strobe must match the oldest expected response.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_valid === 1'b1) begin
         logic [32:0] e;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rd: got data=%h err=%b want no response", rd_data, rd_err);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e[32:1]);
            chk("rd_err", {31'h0, rd_err}, {31'h0, e[0]});
         end
      end
   end

   // Legal load: gdly REQ cycles without gnt, rvalid rdly cycles after gnt.
   task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                          input int gdly, input int rdly, input logic [31:0] w,
                          input logic [31:0] exp);
      int hs;
      exp_q.push_back({exp, 1'b0});
      chk({nm, "_ready_idle"}, {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_addr   = a;
      req_funct3 = f3;
      hs         = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < gdly; i++) begin
         chk({nm, "_mem_req_hold"}, {31'h0, mem_req}, 32'h1);
         chk({nm, "_mem_addr_hold"}, mem_addr, {a[31:2], 2'b00});
         chk({nm, "_ready_busy"}, {31'h0, req_ready}, 32'h0);
         @(negedge clk);
      end
      chk({nm, "_mem_req"}, {31'h0, mem_req}, 32'h1);
      chk({nm, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      for (int i = 1; i < rdly; i++) begin
         chk({nm, "_ready_wait"}, {31'h0, req_ready}, 32'h0);
         @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = w;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk({nm, "_rd_valid"}, {31'h0, rd_valid}, 32'h1);
      chk({nm, "_latency"}, 32'(cyc - hs), 32'(2 + gdly + rdly));
      chk({nm, "_ready_resp"}, {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      chk({nm, "_rd_valid_drop"}, {31'h0, rd_valid}, 32'h0);
      chk({nm, "_ready_back"}, {31'h0, req_ready}, 32'h1);
   endtask

   // Illegal or misaligned request: error strobe one cycle after accept, no memory access.
   task automatic do_bad(input string nm, input logic [31:0] a, input logic [2:0] f3);
      exp_q.push_back({32'h0, 1'b1});
      req_valid  = 1'b1;
      req_addr   = a;
      req_funct3 = f3;
      @(negedge clk);
      req_valid = 1'b0;
      chk({nm, "_no_mem_req"}, {31'h0, mem_req}, 32'h0);
      chk({nm, "_rd_valid"}, {31'h0, rd_valid}, 32'h1);
      @(negedge clk);
      chk({nm, "_no_mem_req2"}, {31'h0, mem_req}, 32'h0);
      chk({nm, "_ready_back"}, {31'h0, req_ready}, 32'h1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_req_ready"}, {31'h0, req_ready}, 32'h1);
      chk({nm, "_mem_req"}, {31'h0, mem_req}, 32'h0);
      chk({nm, "_mem_addr"}, mem_addr, 32'h0);
      chk({nm, "_rd_valid"}, {31'h0, rd_valid}, 32'h0);
      chk({nm, "_rd_data"}, rd_data, 32'h0);
      chk({nm, "_rd_err"}, {31'h0, rd_err}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      req_funct3 = 3'b000;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      #1;
      chk_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_load("lb_103", 32'h103, 3'b000, 0, 1, 32'h80FF1234, 32'hFFFFFF80);
      do_load("lbu_102", 32'h102, 3'b100, 0, 1, 32'h8001ABCD, 32'h00000001);
      do_load("lhu_102", 32'h102, 3'b101, 0, 1, 32'h8001ABCD, 32'h00008001);
      do_load("lh_102", 32'h102, 3'b001, 0, 1, 32'h8001ABCD, 32'hFFFF8001);
      do_load("lb_101", 32'h101, 3'b000, 0, 1, 32'h80FF1234, 32'h00000012);
      do_load("lh_100", 32'h100, 3'b001, 0, 1, 32'h80FF1234, 32'h00001234);

      do_bad("lw_206", 32'h206, 3'b010);
      do_bad("f3_011", 32'h206, 3'b011);
      do_bad("lh_101", 32'h101, 3'b001);
      do_bad("f3_110", 32'h200, 3'b110);

      do_load("lw_300", 32'h300, 3'b010, 5, 2, 32'hDEADBEEF, 32'hDEADBEEF);

      // Timeout: gnt given, rvalid never comes; error on the 4th WAIT cycle.
      exp_q.push_back({32'h0, 1'b1});
      req_valid  = 1'b1;
      req_addr   = 32'h400;
      req_funct3 = 3'b010;
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("to_wait0", {31'h0, rd_valid}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("to_wait_n", {31'h0, rd_valid}, 32'h0);
      end
      @(negedge clk);
      chk("to_rd_valid", {31'h0, rd_valid}, 32'h1);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      @(negedge clk);
      chk("to_late_idle", {31'h0, req_ready}, 32'h1);
      chk("to_late_no_rd", {31'h0, rd_valid}, 32'h0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("to_late_no_mem", {31'h0, mem_req}, 32'h0);
      chk("to_late_no_rd2", {31'h0, rd_valid}, 32'h0);

      // Asynchronous reset mid-WAIT, then a stray rvalid must be ignored.
      do_load("lw_pre", 32'h500, 3'b010, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D);
      req_valid  = 1'b1;
      req_addr   = 32'h504;
      req_funct3 = 3'b010;
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h55AA55AA;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_no_rd", {31'h0, rd_valid}, 32'h0);
         chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
         @(negedge clk);
      end

      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
